// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state and line layout for dcache_ctrl
package cache_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int INDEX_W = 3;
   localparam int OFFSET_W = 2;
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} cache_state_t;
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } line_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side and memory-side signals of the data cache
interface dcache_ctrl_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_ready;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
                   input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata);
   modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
                   output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/cache_store.sv
// cache_store: valid/tag/data arrays, async read port, one sync write port, bulk valid clear
module cache_store #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 27,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               we,
   input  logic [INDEX_W-1:0] widx,
   input  logic [TAG_W-1:0]   wtag,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [INDEX_W-1:0] ridx,
   output logic               rvalid,
   output logic [TAG_W-1:0]   rtag,
   output logic [DATA_W-1:0]  rdata
);
   localparam int SETS = 2**INDEX_W;
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags [SETS];
   logic [DATA_W-1:0] data [SETS];
   always_ff @(posedge clk) begin
      if (clr) valid <= '0;
      else if (we) valid[widx] <= 1'b1;
   end
   // tag/data are never cleared; valid alone decides residency
   always_ff @(posedge clk) begin
      if (we && !clr) begin
         tags[widx] <= wtag;
         data[widx] <= wdata;
      end
   end
   assign rvalid = valid[ridx];
   assign rtag   = tags[ridx];
   assign rdata  = data[ridx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through/no-allocate data cache with refill FSM.
// Define DCACHE_STATS_EN to add saturating stat_hits/stat_misses counters.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_W,
   parameter int DATA_WIDTH  = DATA_W,
   parameter int INDEX_WIDTH = INDEX_W
) (
   input logic          clk,
   input logic          rst,
   dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  stat_hits,
   output logic [31:0]  stat_misses
`endif
);
   localparam int WW = ADDR_WIDTH - OFFSET_W;
   localparam int TW = WW - INDEX_WIDTH;
   cache_state_t state, state_n;
   logic mem_req_q, mem_we_q, hit_q;
   logic [WW-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q, line_data;
   logic [TW-1:0] line_tag;
   logic line_valid, hit, ld_hit, issue, ack, st_we;
   logic unused_addr;
   assign unused_addr = ^bus.cpu_addr[OFFSET_W-1:0];
   assign hit    = line_valid && line_tag == bus.cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_W];
   assign ld_hit = state == IDLE && bus.cpu_req && !bus.cpu_we && hit;
   assign issue  = state == IDLE && state_n != IDLE;
   assign ack    = mem_req_q && bus.mem_ack;
   // a store that missed at issue time must not touch the line
   assign st_we  = ack && (!mem_we_q || hit_q) && !rst;
   cache_store #(.INDEX_W(INDEX_WIDTH), .TAG_W(TW), .DATA_W(DATA_WIDTH)) u_store (
      .clk(clk), .clr(rst), .we(st_we),
      .widx(waddr_q[INDEX_WIDTH-1:0]), .wtag(waddr_q[WW-1:INDEX_WIDTH]),
      .wdata(mem_we_q ? wdata_q : bus.mem_rdata),
      .ridx(bus.cpu_addr[INDEX_WIDTH+OFFSET_W-1:OFFSET_W]),
      .rvalid(line_valid), .rtag(line_tag), .rdata(line_data)
   );
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:             state_n = !bus.cpu_req ? IDLE : bus.cpu_we ? WR_THRU : hit ? IDLE : RD_MISS;
         RD_MISS, WR_THRU: state_n = bus.mem_ack ? RESP : state;
         RESP:             state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         hit_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else if (issue) begin
         mem_req_q <= 1'b1;
         mem_we_q  <= bus.cpu_we;
         hit_q     <= hit;
         waddr_q   <= bus.cpu_addr[ADDR_WIDTH-1:OFFSET_W];
         wdata_q   <= bus.cpu_wdata;
      end else if (ack) begin
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         rdata_q   <= mem_we_q ? rdata_q : bus.mem_rdata;
      end
   end
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = {waddr_q, {OFFSET_W{1'b0}}};
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_ready = !rst && (ld_hit || state == RESP);
   assign bus.cpu_rdata = ld_hit ? line_data : rdata_q;
`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else begin
         if (ld_hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
         if (issue && state_n == RD_MISS && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
   end
`endif
endmodule
